fruit_renderer: RTL
===================

Name: fruit_renderer

Overview:
Datapath and pixel engine answering the game control FSM's draw and move requests. It holds the fruit position and colour, and steps the fruit on each move request. It sweeps the full-screen backgrounds and the 16x16 fruit sprite into the VGA adapter, one pixel per clock. It returns background_drawn / fruit_drawn as the completion side of the control handshake.

Parameters:
SCREEN_W, 160, horizontal pixels
SCREEN_H, 120, vertical pixels
FRUIT_SIZE, 16, sprite edge in pixels
FALL_STEP, 2, y increment per move_fruit cycle
BG_COLOUR, 24'h2E1A0E, game background colour
START_COLOUR, 24'h102040, start-screen colour
OVER_COLOUR, 24'h400000, game-over colour

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
new_fruit  in  1  level; reload start position while high
move_fruit  in  1  one step per cycle high
draw_fruit  in  1  level request: draw sprite
draw_background  in  1  level request: game background
draw_start_background  in  1  level request: start screen
draw_gameover_background  in  1  level request: game-over screen
fruit_x_position  out  8  sprite top-left x
fruit_y_position  out  7  sprite top-left y
fruit_colour  out  24  current fruit colour
fruit_drawn  out  1  sprite sweep complete
background_drawn  out  1  background sweep complete
vga_x  out  8  pixel x
vga_y  out  7  pixel y
vga_colour  out  24  pixel colour
vga_plot  out  1  pixel write strobe

Behaviour:
- Interface: one clock `clock`; reset `reset` is synchronous, active-high.
- Reset values:
  - fruit_x_position=72, fruit_y_position=0, fruit_colour=palette[0].
  - fruit_drawn=0, background_drawn=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
  - LFSR=8'hA5; state IDLE.
- 8-bit LFSR (taps 8,6,5,4) advances every non-reset cycle.
- Position update (all states):
  - new_fruit=1 and move_fruit=0: x <= LFSR mod 144; y <= 0; colour <= palette[LFSR[1:0]]. This repeats every cycle new_fruit is high; the value is frozen when it drops.
  - move_fruit=1: y <= min(y+FALL_STEP, 119), saturating. move_fruit has priority over new_fruit.
- State machine:
  - IDLE:
    - Any background request goes to BG_SWEEP and latches the colour. Priority is start > gameover > game.
    - Otherwise, if draw_fruit, go to FRUIT_SWEEP and latch x, y, colour.
    - The counter is zeroed on entry.
  - BG_SWEEP:
    - vga_plot=1; vga_x/vga_y = counter; raster order, x fastest.
    - 19200 cycles; after pixel (159,119) go to BG_DONE.
  - FRUIT_SWEEP:
    - vga_plot=1 for 256 cycles; pixel = latched position + (col,row).
    - Pixels with x>159 or y>119 are suppressed (vga_plot=0) but still counted.
    - Corner pixels (col,row in {0,15}x{0,15}) use the background colour instead, giving a rounded look.
    - After the last pixel go to FRUIT_DONE.
  - BG_DONE / FRUIT_DONE:
    - Hold background_drawn / fruit_drawn = 1 while the request stays high.
    - Return to IDLE the cycle after the request drops; the done flag clears at the same time.
- Drawing latency: vga outputs are registered. The first pixel appears 1 cycle after the sweep state is entered.
- A request dropped mid-sweep aborts: next cycle IDLE, vga_plot=0, no done pulse.
- Simultaneous draw_fruit and a background request: the background wins.
- A position change during FRUIT_SWEEP does not affect the in-flight sprite.
- Reset mid-sweep: next cycle IDLE, all outputs at reset values.

Decomposition:
- Shared package fruit_pkg holds:
  - SCREEN_W/H, FRUIT_SIZE and the colour constants;
  - the 4-entry fruit palette (red, orange, green, yellow);
  - the state enum for IDLE, BG_SWEEP, FRUIT_SWEEP, BG_DONE, FRUIT_DONE.
- One sub-module, pixel_sweeper:
  - Holds the generic width x height raster counter with start/abort/done.
  - Is instantiated once and reused for both sweeps, with size selected per state.

Test Plan:
- Reset, then draw_start_background held high -> vga_plot high for exactly 19200 cycles with colour START_COLOUR, last pixel (159,119). background_drawn rises the following cycle and clears 1 cycle after the request drops.
- new_fruit pulsed 1 cycle with LFSR=8'hA5 -> x=165 mod 144=21, y=0, colour palette[1]. Then 3 move_fruit cycles -> y=6.
- y=118 plus one move_fruit cycle -> y=119, saturated. A further move leaves it at 119.
- Fruit at (150,110), draw_fruit held -> 256 sweep cycles but only 100 plotted pixels, corners in background colour. fruit_drawn then stays high until draw_fruit drops.
- draw_background dropped at cycle 500 of the sweep -> vga_plot=0 the next cycle, state IDLE, background_drawn never asserted.
- draw_fruit and draw_gameover_background raised in the same cycle -> a 19200-pixel OVER_COLOUR sweep, no fruit pixels.

Source files
------------

// File: rtl/fruit_pkg.sv
// Shared constants, palette and state encoding for the fruit renderer.
package fruit_pkg;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int FRUIT_SIZE = 16;
  localparam int FALL_STEP  = 2;
  localparam int X_RANGE    = SCREEN_W - FRUIT_SIZE;

  localparam logic [23:0] BG_COLOUR    = 24'h2E1A0E;
  localparam logic [23:0] START_COLOUR = 24'h102040;
  localparam logic [23:0] OVER_COLOUR  = 24'h400000;

  localparam logic [7:0] LFSR_SEED     = 8'hA5;
  localparam logic [7:0] FRUIT_X_START = 8'd72;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BG_SWEEP,
    ST_FRUIT_SWEEP,
    ST_BG_DONE,
    ST_FRUIT_DONE
  } state_e;

  typedef enum logic [1:0] {
    BG_GAME,
    BG_START,
    BG_OVER
  } bg_sel_e;

  // Fruit palette: red, orange, green, yellow.
  function automatic logic [23:0] palette(input logic [1:0] idx);
    case (idx)
      2'd0:    palette = 24'hFF0000;
      2'd1:    palette = 24'hFF8000;
      2'd2:    palette = 24'h00FF00;
      default: palette = 24'hFFFF00;
    endcase
  endfunction

endpackage

// File: rtl/fruit_renderer_pixel_sweeper.sv
// Raster counter: walks (col,row) over width x height, column fastest.
module pixel_sweeper (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       step_i,
  input  logic [7:0] width_i,
  input  logic [6:0] height_i,
  output logic [7:0] col_o,
  output logic [6:0] row_o,
  output logic       last_o
);

  logic [7:0] col_q, col_d;
  logic [6:0] row_q, row_d;
  logic       col_last, row_last;

  assign col_last = (col_q == width_i - 8'd1);
  assign row_last = (row_q == height_i - 7'd1);
  assign last_o   = col_last && row_last;
  assign col_o    = col_q;
  assign row_o    = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (step_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? 7'd0 : row_q + 7'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/fruit_renderer.sv
// Fruit position/colour datapath and background/sprite pixel engine feeding the VGA adapter.
module fruit_renderer
  import fruit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        new_fruit,
  input  logic        move_fruit,
  input  logic        draw_fruit,
  input  logic        draw_background,
  input  logic        draw_start_background,
  input  logic        draw_gameover_background,
  output logic [7:0]  fruit_x_position,
  output logic [6:0]  fruit_y_position,
  output logic [23:0] fruit_colour,
  output logic        fruit_drawn,
  output logic        background_drawn,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [23:0] vga_colour,
  output logic        vga_plot
);

  state_e      state_q, state_d;
  bg_sel_e     bg_sel_q, bg_sel_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [7:0]  fx_q, fx_d;
  logic [6:0]  fy_q, fy_d;
  logic [23:0] fcol_q, fcol_d;
  logic [7:0]  spr_x_q, spr_x_d;
  logic [6:0]  spr_y_q, spr_y_d;
  logic [23:0] spr_col_q, spr_col_d;
  logic [23:0] bg_col_q, bg_col_d;
  logic [7:0]  vx_q, vx_d;
  logic [6:0]  vy_q, vy_d;
  logic [23:0] vcol_q, vcol_d;
  logic        plot_q, plot_d;
  logic        bg_done_q, bg_done_d;
  logic        fr_done_q, fr_done_d;

  logic [7:0]  col;
  logic [6:0]  row;
  logic        last;
  logic        fruit_sweep;
  logic        sel_req;
  logic [7:0]  x_mod;
  logic [7:0]  y_sum;
  logic [8:0]  px;
  logic [7:0]  py;
  logic        corner;

  assign fruit_sweep = (state_q == ST_FRUIT_SWEEP);

  pixel_sweeper u_sweeper (
    .clk_i    (clock),
    .rst_i    (reset),
    .clear_i  (state_q == ST_IDLE),
    .step_i   ((state_q == ST_BG_SWEEP) || fruit_sweep),
    .width_i  (fruit_sweep ? 8'(FRUIT_SIZE) : 8'(SCREEN_W)),
    .height_i (fruit_sweep ? 7'(FRUIT_SIZE) : 7'(SCREEN_H)),
    .col_o    (col),
    .row_o    (row),
    .last_o   (last)
  );

  // Position, colour and LFSR update; runs independently of the drawing FSM.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    x_mod  = (lfsr_q >= 8'(X_RANGE)) ? lfsr_q - 8'(X_RANGE) : lfsr_q;
    y_sum  = {1'b0, fy_q} + 8'(FALL_STEP);
    fx_d   = fx_q;
    fy_d   = fy_q;
    fcol_d = fcol_q;
    if (move_fruit) begin
      fy_d = (y_sum > 8'(SCREEN_H - 1)) ? 7'(SCREEN_H - 1) : y_sum[6:0];
    end else if (new_fruit) begin
      fx_d   = x_mod;
      fy_d   = '0;
      fcol_d = palette(lfsr_q[1:0]);
    end
  end

  always_comb begin
    case (bg_sel_q)
      BG_START: sel_req = draw_start_background;
      BG_OVER:  sel_req = draw_gameover_background;
      default:  sel_req = draw_background;
    endcase
    px     = {1'b0, spr_x_q} + {1'b0, col};
    py     = {1'b0, spr_y_q} + {1'b0, row};
    corner = (col == 8'd0 || col == 8'(FRUIT_SIZE - 1)) &&
             (row == 7'd0 || row == 7'(FRUIT_SIZE - 1));
  end

  always_comb begin
    state_d   = state_q;
    bg_sel_d  = bg_sel_q;
    bg_col_d  = bg_col_q;
    spr_x_d   = spr_x_q;
    spr_y_d   = spr_y_q;
    spr_col_d = spr_col_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    vcol_d    = vcol_q;
    plot_d    = 1'b0;
    bg_done_d = 1'b0;
    fr_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (draw_start_background) begin
          state_d  = ST_BG_SWEEP;
          bg_sel_d = BG_START;
          bg_col_d = START_COLOUR;
        end else if (draw_gameover_background) begin
          state_d  = ST_BG_SWEEP;
          bg_sel_d = BG_OVER;
          bg_col_d = OVER_COLOUR;
        end else if (draw_background) begin
          state_d  = ST_BG_SWEEP;
          bg_sel_d = BG_GAME;
          bg_col_d = BG_COLOUR;
        end else if (draw_fruit) begin
          state_d   = ST_FRUIT_SWEEP;
          spr_x_d   = fx_q;
          spr_y_d   = fy_q;
          spr_col_d = fcol_q;
        end
      end
      ST_BG_SWEEP: begin
        if (!sel_req) begin
          state_d = ST_IDLE;
        end else begin
          plot_d = 1'b1;
          vx_d   = col;
          vy_d   = row;
          vcol_d = bg_col_q;
          if (last) state_d = ST_BG_DONE;
        end
      end
      ST_FRUIT_SWEEP: begin
        if (!draw_fruit) begin
          state_d = ST_IDLE;
        end else begin
          // Off-screen pixels are skipped but still consume a count.
          plot_d = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
          vx_d   = px[7:0];
          vy_d   = py[6:0];
          vcol_d = corner ? BG_COLOUR : spr_col_q;
          if (last) state_d = ST_FRUIT_DONE;
        end
      end
      ST_BG_DONE: begin
        if (sel_req) bg_done_d = 1'b1;
        else         state_d   = ST_IDLE;
      end
      ST_FRUIT_DONE: begin
        if (draw_fruit) fr_done_d = 1'b1;
        else            state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bg_sel_q  <= BG_GAME;
      bg_col_q  <= BG_COLOUR;
      lfsr_q    <= LFSR_SEED;
      fx_q      <= FRUIT_X_START;
      fy_q      <= '0;
      fcol_q    <= palette(2'd0);
      spr_x_q   <= '0;
      spr_y_q   <= '0;
      spr_col_q <= '0;
      vx_q      <= '0;
      vy_q      <= '0;
      vcol_q    <= '0;
      plot_q    <= 1'b0;
      bg_done_q <= 1'b0;
      fr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bg_sel_q  <= bg_sel_d;
      bg_col_q  <= bg_col_d;
      lfsr_q    <= lfsr_d;
      fx_q      <= fx_d;
      fy_q      <= fy_d;
      fcol_q    <= fcol_d;
      spr_x_q   <= spr_x_d;
      spr_y_q   <= spr_y_d;
      spr_col_q <= spr_col_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      vcol_q    <= vcol_d;
      plot_q    <= plot_d;
      bg_done_q <= bg_done_d;
      fr_done_q <= fr_done_d;
    end
  end

  assign fruit_x_position = fx_q;
  assign fruit_y_position = fy_q;
  assign fruit_colour     = fcol_q;
  assign fruit_drawn      = fr_done_q;
  assign background_drawn = bg_done_q;
  assign vga_x            = vx_q;
  assign vga_y            = vy_q;
  assign vga_colour       = vcol_q;
  assign vga_plot         = plot_q;

endmodule
